// File: rtl/nibbler_io_ports_if.sv
// Decode/execute-side port bus for nibbler_io_ports: IN/OUT strobes, port select, data.
// Latency 1 cycle on rd_data/rd_valid; no backpressure, every strobe is accepted.
interface nibbler_io_ports_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
);
    logic [ADDR_W-1:0] port_sel;
    logic              in_en;
    logic              rd_mode;
    logic              out_en;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output port_sel,
        output in_en,
        output rd_mode,
        output out_en,
        output wr_data,
        input  rd_data,
        input  rd_valid
    );

    modport slave (
        input  port_sel,
        input  in_en,
        input  rd_mode,
        input  out_en,
        input  wr_data,
        output rd_data,
        output rd_valid
    );
endinterface

// File: rtl/nibbler_io_ports.sv
// Multi-port I/O for Nibbler: synchronised, debounced inputs with rising-edge latches, output latches.
// Reads/writes take effect on the strobe edge (1-cycle latency); no backpressure.
module nibbler_io_ports #(
    parameter int DATA_W     = 4,
    parameter int N_PORTS    = 4,
    parameter int ADDR_W     = 2,
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 3
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic [N_PORTS*DATA_W-1:0] pushbuttons_i,
    nibbler_io_ports_if.slave         bus,
    output logic [N_PORTS*DATA_W-1:0] ff_out_o,
    output logic [N_PORTS-1:0]        edge_pending_o
);

    localparam int               NB      = N_PORTS * DATA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [NB-1:0]             sync1_q;
    logic [NB-1:0]             sync2_q;
    logic [NB-1:0]             deb_q,  deb_d;
    logic [NB-1:0][CNT_W-1:0]  cnt_q,  cnt_d;
    logic [NB-1:0]             edge_q, edge_d;
    logic [NB-1:0]             rise;
    logic [NB-1:0]             clr_mask;
    logic [NB-1:0]             ff_out_q, ff_out_d;
    logic [DATA_W-1:0]         rd_data_q, rd_data_d;
    logic                      rd_valid_q, rd_valid_d;
    logic [N_PORTS-1:0]        port_hit;
    logic [DATA_W-1:0]         sel_lvl;
    logic [DATA_W-1:0]         sel_edge;

    // Per-bit debounce: the counter only advances while the synchronised input disagrees with d.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        for (int b = 0; b < NB; b++) begin
            if (sync2_q[b] != deb_q[b]) begin
                if (cnt_q[b] == CNT_MAX) begin
                    deb_d[b] = sync2_q[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + 1'b1;
                end
            end
        end
    end

    assign rise = deb_d & ~deb_q;

    // Out-of-range selects match no port, so reads return 0 and writes are dropped naturally.
    always_comb begin
        port_hit = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            port_hit[p] = (bus.port_sel == ADDR_W'(p));
        end
    end

    always_comb begin
        sel_lvl  = '0;
        sel_edge = '0;
        clr_mask = '0;
        ff_out_d = ff_out_q;
        for (int p = 0; p < N_PORTS; p++) begin
            if (port_hit[p]) begin
                sel_lvl  = deb_q[p*DATA_W +: DATA_W];
                sel_edge = edge_q[p*DATA_W +: DATA_W];
                if (bus.in_en && bus.rd_mode) begin
                    clr_mask[p*DATA_W +: DATA_W] = '1;
                end
                if (bus.out_en) begin
                    ff_out_d[p*DATA_W +: DATA_W] = bus.wr_data;
                end
            end
        end
    end

    // A rise on the same edge as a clearing read wins, so no key press is lost.
    assign edge_d = (edge_q & ~clr_mask) | rise;

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (bus.in_en) begin
            rd_data_d  = bus.rd_mode ? sel_edge : sel_lvl;
            rd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            cnt_q      <= '0;
            edge_q     <= '0;
            ff_out_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            sync1_q    <= pushbuttons_i;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            cnt_q      <= cnt_d;
            edge_q     <= edge_d;
            ff_out_q   <= ff_out_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        edge_pending_o = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            edge_pending_o[p] = |edge_q[p*DATA_W +: DATA_W];
        end
    end

    assign ff_out_o     = ff_out_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_nibbler_io_ports.sv
// Scoreboard bench for nibbler_io_ports: reads push expected data, a negedge monitor pops on rd_valid.
module tb_nibbler_io_ports;

    logic        clk;
    logic        rst;
    logic [15:0] pb;
    logic [15:0] ff_out;
    logic [3:0]  edge_pending;

    int errors;
    int checks;
    logic [3:0] exp_q[$];

    nibbler_io_ports_if #(.DATA_W(4), .ADDR_W(3)) bus ();

    nibbler_io_ports #(
        .DATA_W(4), .N_PORTS(4), .ADDR_W(3), .DEB_CYCLES(4), .CNT_W(3)
    ) dut (
        .clock_i        (clk),
        .reset_i        (rst),
        .pushbuttons_i  (pb),
        .bus            (bus),
        .ff_out_o       (ff_out),
        .edge_pending_o (edge_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] sel, input logic mode, input logic [3:0] exp);
        bus.in_en    = 1'b1;
        bus.rd_mode  = mode;
        bus.port_sel = sel;
        exp_q.push_back(exp);
        tick(1);
    endtask

    task automatic wr(input logic [2:0] sel, input logic [3:0] dat);
        bus.out_en   = 1'b1;
        bus.port_sel = sel;
        bus.wr_data  = dat;
        tick(1);
        bus.out_en   = 1'b0;
    endtask

    task automatic idle();
        bus.in_en  = 1'b0;
        bus.out_en = 1'b0;
    endtask

    // Monitor: every rd_valid cycle must match the oldest outstanding expected read.
    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rd_valid", 32'(bus.rd_data), 32'hFFFF_FFFF);
            end else begin
                chk("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        pb  = 16'h000C;
        bus.port_sel = '0;
        bus.in_en    = 1'b0;
        bus.rd_mode  = 1'b0;
        bus.out_en   = 1'b0;
        bus.wr_data  = '0;

        // Reset state, then 6 edges to debounce port0 = C
        tick(1);
        chk("rst_rd_data", 32'(bus.rd_data), 0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 0);
        chk("rst_ff_out", 32'(ff_out), 0);
        chk("rst_edge_pending", 32'(edge_pending), 0);
        rst = 1'b0;
        tick(5);
        chk("deb_edge5_pending", 32'(edge_pending), 0);
        tick(1);
        chk("deb_edge6_pending", 32'(edge_pending), 32'h1);

        // Level then edge reads back-to-back, then a repeat edge read
        rd(3'd0, 1'b0, 4'hC);
        rd(3'd0, 1'b1, 4'hC);
        chk("btb_rd_valid", 32'(bus.rd_valid), 1);
        chk("edge_clr_pending", 32'(edge_pending), 0);
        rd(3'd0, 1'b1, 4'h0);
        idle();
        tick(1);
        chk("rd_valid_drop", 32'(bus.rd_valid), 0);

        // Glitch rejection on port1 bit0: 3-cycle pulse filtered, 4-cycle pulse accepted
        pb[4] = 1'b1;
        tick(3);
        pb[4] = 1'b0;
        tick(8);
        chk("glitch3_pending", 32'(edge_pending), 0);
        rd(3'd1, 1'b0, 4'h0);
        idle();
        pb[4] = 1'b1;
        tick(4);
        pb[4] = 1'b0;
        tick(2);
        chk("pulse4_pending", 32'(edge_pending), 32'h2);
        rd(3'd1, 1'b0, 4'h1);
        idle();
        tick(6);
        rd(3'd1, 1'b1, 4'h1);
        rd(3'd1, 1'b0, 4'h0);
        idle();

        // Output writes, and a write concurrent with a level read of port3
        pb[15:12] = 4'h9;
        tick(7);
        chk("port3_pending", 32'(edge_pending), 32'h8);
        wr(3'd2, 4'hA);
        chk("ff_out_p2", 32'(ff_out), 32'h0A00);
        bus.in_en   = 1'b1;
        bus.rd_mode = 1'b0;
        bus.out_en  = 1'b1;
        bus.wr_data = 4'h5;
        bus.port_sel = 3'd3;
        exp_q.push_back(4'h9);
        tick(1);
        idle();
        chk("ff_out_p3_dual", 32'(ff_out), 32'h5A00);
        wr(3'd0, 4'h5);
        chk("ff_out_p0", 32'(ff_out), 32'h5A05);

        // Set-wins: bit1 latched first, bit0 rises on the edge of the clearing read
        rd(3'd3, 1'b1, 4'h9);
        idle();
        pb[3:0] = 4'hE;
        tick(7);
        pb[3:0] = 4'hF;
        tick(5);
        rd(3'd0, 1'b1, 4'h2);
        idle();
        chk("setwins_pending", 32'(edge_pending), 32'h1);
        rd(3'd0, 1'b1, 4'h1);
        idle();
        tick(1);
        chk("setwins_cleared", 32'(edge_pending), 0);

        // Out-of-range select: read gives 0, write dropped, no latch disturbed
        wr(3'd5, 4'hF);
        chk("oor_write", 32'(ff_out), 32'h5A05);
        rd(3'd5, 1'b1, 4'h0);
        idle();
        chk("oor_rd_valid", 32'(bus.rd_valid), 1);

        // Reset mid-debounce on port2: partial count discarded, full 6 edges again
        pb[11:8] = 4'h3;
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_ff_out", 32'(ff_out), 0);
        chk("mid_rst_pending", 32'(edge_pending), 0);
        chk("mid_rst_rd_data", 32'(bus.rd_data), 0);
        tick(5);
        chk("restart_edge5", 32'(edge_pending), 0);
        tick(1);
        chk("restart_edge6", 32'(edge_pending), 32'hD);
        rd(3'd2, 1'b0, 4'h3);
        idle();
        tick(2);
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
